ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter (instruction fetch, data memory) sharing one registered RAM port.
// Optional bus-wait timeout is enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        dm_ce_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER} state_t;

    state_t state;
    logic   last_dm;    // 1 when the most recent completed grant went to the data port
    logic   grant_dm;
    logic   grant_if;
    logic   timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ram_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    // Data port has priority, except it yields one slot when it won last time.
    always_comb begin
        grant_dm = dm_ce_i && !(last_dm && if_ce_i);
        grant_if = if_ce_i && !grant_dm;
    end

    assign stallreq_o = (if_ce_i & ~if_ack_o) | (dm_ce_i & ~dm_ack_o);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout = (state != IDLE) && !bus_ack_i && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= timeout;
            if (state == IDLE)
                wait_cnt <= '0;
            else if (!bus_ack_i)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // NOTE: synchronous reset lives inside the clocked block and all state uses <=,
    // so every register here sees the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_dm     <= 1'b0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The ack cycle is a bus-idle gap; the requester still shows ce then.
                    if (!if_ack_o && !dm_ack_o) begin
                        if (grant_dm) begin
                            state       <= DM_XFER;
                            bus_ce_o    <= 1'b1;
                            bus_we_o    <= dm_we_i;
                            bus_addr_o  <= dm_addr_i;
                            bus_sel_o   <= dm_sel_i;
                            bus_wdata_o <= dm_wdata_i;
                        end else if (grant_if) begin
                            state       <= IF_XFER;
                            bus_ce_o    <= 1'b1;
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= if_addr_i;
                            bus_sel_o   <= 4'b1111;
                            bus_wdata_o <= '0;
                        end
                    end
                end
                IF_XFER: begin
                    if (bus_ack_i || timeout) begin
                        state     <= IDLE;
                        bus_ce_o  <= 1'b0;
                        last_dm   <= 1'b0;
                        if_ack_o  <= 1'b1;
                        if_data_o <= timeout ? 32'd0 : bus_rdata_i;
                    end
                end
                DM_XFER: begin
                    if (bus_ack_i || timeout) begin
                        state    <= IDLE;
                        bus_ce_o <= 1'b0;
                        last_dm  <= 1'b1;
                        dm_ack_o <= 1'b1;
                        if (timeout)
                            dm_rdata_o <= '0;
                        else if (!bus_we_o)
                            dm_rdata_o <= bus_rdata_i;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_ce_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
